util_pulse_gen: RTL and testbench

- Edge-to-waveform generator: the transmit side for our edge-detect/filter path.
- Turns single-cycle event strobes into clean output waveforms with guaranteed minimum high and low widths.
- A downstream synchroniser/edge detector with a hold requirement therefore always sees a valid, countable edge.
- Sits at the output of control FSMs that drive strobes, triggers or handshake lines across clock domains or off-chip.

---
 rtl/util_pulse_gen.sv | 157 +++++++++++++++
 tb/tb_util_pulse_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/util_pulse_gen.sv
// -----------------------------------------------------------------------------
// util_pulse_gen
//
// Turns single-cycle event strobes into clean output waveforms with guaranteed
// minimum high and low widths. A downstream synchroniser or edge detector with
// a hold requirement therefore always sees a valid, countable edge.
//
// Modes (C_MODE):
//   "pulse"  : each trigger emits one active pulse of HIGH_CYCLE cycles,
//              followed by a guard of LOW_CYCLE cycles at the idle level.
//   "toggle" : each trigger flips dout, then holds it for HIGH_CYCLE cycles.
//   other    : generator disabled; dout stays idle, triggers ignored.
//
// One trigger can be queued while busy. A further trigger is dropped and
// counted in a saturating counter.
//
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   trig     in   event strobe, every high cycle is one event
//   dout     out  generated waveform (registered)
//   busy     out  high while not IDLE (registered)
//   pend     out  one trigger is queued (registered)
//   drop     out  single-cycle strobe, a trigger was discarded (registered)
//   drop_cnt out  saturating count of discarded triggers (registered)
// -----------------------------------------------------------------------------
module util_pulse_gen #(
    parameter string C_MODE       = "pulse",
    parameter int    HIGH_CYCLE   = 2,
    parameter int    LOW_CYCLE    = 2,
    parameter logic  C_IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        trig,
    output logic        dout,
    output logic        busy,
    output logic        pend,
    output logic        drop,
    output logic [15:0] drop_cnt
);

    localparam logic        MODE_TOGGLE = (C_MODE == "toggle");
    localparam logic        MODE_VALID  = (C_MODE == "pulse") || (C_MODE == "toggle");
    localparam logic [15:0] HIGH_LOAD   = 16'(HIGH_CYCLE - 1);
    localparam logic [15:0] LOW_LOAD    = 16'(LOW_CYCLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GUARD  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_dout;
    logic        r_busy;
    logic        r_pend;
    logic        r_drop;
    logic [15:0] r_drop_cnt;
    logic [15:0] r_cnt;

    logic w_phase_done;
    logic w_pend_take;

    assign w_phase_done = (r_cnt == 16'd0);

    // The queued trigger is consumed at the end of GUARD, or at the end of
    // ACTIVE in toggle mode (toggle mode has no guard phase).
    assign w_pend_take = w_phase_done && r_pend &&
                         ((r_state == S_GUARD) ||
                          ((r_state == S_ACTIVE) && MODE_TOGGLE));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_dout     <= C_IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_pend     <= 1'b0;
            r_drop     <= 1'b0;
            r_drop_cnt <= 16'd0;
            r_cnt      <= 16'd0;
        end else begin
            r_drop <= 1'b0;
            if (MODE_VALID) begin
                // Queue / drop handling for triggers arriving while busy.
                // A trigger landing on the same edge the queue is consumed
                // simply refills the queue, so it is never dropped.
                if (r_state != S_IDLE) begin
                    if (trig) begin
                        if (w_pend_take || !r_pend) begin
                            r_pend <= 1'b1;
                        end else begin
                            r_drop <= 1'b1;
                            if (r_drop_cnt != 16'hFFFF) begin
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end
                        end
                    end else if (w_pend_take) begin
                        r_pend <= 1'b0;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        if (trig) begin
                            r_state <= S_ACTIVE;
                            r_busy  <= 1'b1;
                            r_cnt   <= HIGH_LOAD;
                            r_dout  <= MODE_TOGGLE ? ~r_dout : ~C_IDLE_LEVEL;
                        end
                    end
                    S_ACTIVE: begin
                        if (!w_phase_done) begin
                            r_cnt <= r_cnt - 16'd1;
                        end else if (!MODE_TOGGLE) begin
                            r_state <= S_GUARD;
                            r_dout  <= C_IDLE_LEVEL;
                            r_cnt   <= LOW_LOAD;
                        end else if (r_pend) begin
                            // Toggle mode: serve the queued trigger directly.
                            r_cnt  <= HIGH_LOAD;
                            r_dout <= ~r_dout;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_GUARD: begin
                        if (!w_phase_done) begin
                            r_cnt <= r_cnt - 16'd1;
                        end else if (r_pend) begin
                            r_state <= S_ACTIVE;
                            r_cnt   <= HIGH_LOAD;
                            r_dout  <= ~C_IDLE_LEVEL;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_dout  <= C_IDLE_LEVEL;
                        r_cnt   <= 16'd0;
                    end
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign busy     = r_busy;
    assign pend     = r_pend;
    assign drop     = r_drop;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_util_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_util_pulse_gen
//
// Directed bench for util_pulse_gen. Five instances with different parameter
// sets share one clock; each has its own reset and trigger. Expected
// waveforms are hand-derived per cycle and stored in small vector tables.
// -----------------------------------------------------------------------------
module tb_util_pulse_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_v [5];
    logic        trig_v [5];
    logic        dout_v [5];
    logic        busy_v [5];
    logic        pend_v [5];
    logic        drop_v [5];
    logic [15:0] cnt_v  [5];

    int checks = 0;
    int errors = 0;

    // 0: pulse H3 L2   1: pulse H3 L2   2: toggle H4   3: pulse H1 L1   4: illegal mode
    util_pulse_gen #(.C_MODE("pulse"),  .HIGH_CYCLE(3), .LOW_CYCLE(2), .C_IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rstn(rstn_v[0]), .trig(trig_v[0]), .dout(dout_v[0]),
        .busy(busy_v[0]), .pend(pend_v[0]), .drop(drop_v[0]), .drop_cnt(cnt_v[0]));
    util_pulse_gen #(.C_MODE("pulse"),  .HIGH_CYCLE(3), .LOW_CYCLE(2), .C_IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .rstn(rstn_v[1]), .trig(trig_v[1]), .dout(dout_v[1]),
        .busy(busy_v[1]), .pend(pend_v[1]), .drop(drop_v[1]), .drop_cnt(cnt_v[1]));
    util_pulse_gen #(.C_MODE("toggle"), .HIGH_CYCLE(4), .LOW_CYCLE(2), .C_IDLE_LEVEL(1'b0)) u_c (
        .clk(clk), .rstn(rstn_v[2]), .trig(trig_v[2]), .dout(dout_v[2]),
        .busy(busy_v[2]), .pend(pend_v[2]), .drop(drop_v[2]), .drop_cnt(cnt_v[2]));
    util_pulse_gen #(.C_MODE("pulse"),  .HIGH_CYCLE(1), .LOW_CYCLE(1), .C_IDLE_LEVEL(1'b0)) u_d (
        .clk(clk), .rstn(rstn_v[3]), .trig(trig_v[3]), .dout(dout_v[3]),
        .busy(busy_v[3]), .pend(pend_v[3]), .drop(drop_v[3]), .drop_cnt(cnt_v[3]));
    util_pulse_gen #(.C_MODE("bogus"),  .HIGH_CYCLE(2), .LOW_CYCLE(2), .C_IDLE_LEVEL(1'b0)) u_e (
        .clk(clk), .rstn(rstn_v[4]), .trig(trig_v[4]), .dout(dout_v[4]),
        .busy(busy_v[4]), .pend(pend_v[4]), .drop(drop_v[4]), .drop_cnt(cnt_v[4]));

    // Per-cycle stimulus and expectation tables (index = cycle of the run).
    bit t_tab [16];
    bit d_tab [16];
    bit b_tab [16];
    bit p_tab [16];
    bit r_tab [16];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check outputs of cycle i, drive trig for cycle i, advance one edge.
    task automatic run(input int sel, input string name, input logic [15:0] cnt_exp);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s dout[%0d]", name, i), {15'd0, dout_v[sel]}, {15'd0, d_tab[i]});
            check($sformatf("%s busy[%0d]", name, i), {15'd0, busy_v[sel]}, {15'd0, b_tab[i]});
            check($sformatf("%s pend[%0d]", name, i), {15'd0, pend_v[sel]}, {15'd0, p_tab[i]});
            check($sformatf("%s drop[%0d]", name, i), {15'd0, drop_v[sel]}, {15'd0, r_tab[i]});
            trig_v[sel] = t_tab[i];
            tick();
        end
        trig_v[sel] = 1'b0;
        check($sformatf("%s drop_cnt", name), cnt_v[sel], cnt_exp);
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            rstn_v[k] = 1'b0;
            trig_v[k] = 1'b0;
        end

        // Reset held 3 cycles with trig toggling on every instance.
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 5; k++) trig_v[k] = (c % 2 == 0);
            tick();
            for (int k = 0; k < 5; k++) begin
                check($sformatf("rst%0d dut%0d dout", c, k), {15'd0, dout_v[k]}, 16'd0);
                check($sformatf("rst%0d dut%0d busy", c, k), {15'd0, busy_v[k]}, 16'd0);
                check($sformatf("rst%0d dut%0d pend", c, k), {15'd0, pend_v[k]}, 16'd0);
                check($sformatf("rst%0d dut%0d cnt",  c, k), cnt_v[k], 16'd0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            trig_v[k] = 1'b0;
            rstn_v[k] = 1'b1;
        end
        tick();

        // Pulse H3 L2, single trigger.
        t_tab = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        d_tab = '{0,1,1,1,0,0,0,0, 0,0,0,0,0,0,0,0};
        b_tab = '{0,1,1,1,1,1,0,0, 0,0,0,0,0,0,0,0};
        p_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        r_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        run(0, "single", 16'd0);

        // Pulse H3 L2, triggers at 0, 2, 3: queue then drop.
        t_tab = '{1,0,1,1,0,0,0,0, 0,0,0,0,0,0,0,0};
        d_tab = '{0,1,1,1,0,0,1,1, 1,0,0,0,0,0,0,0};
        b_tab = '{0,1,1,1,1,1,1,1, 1,1,1,0,0,0,0,0};
        p_tab = '{0,0,0,1,1,1,0,0, 0,0,0,0,0,0,0,0};
        r_tab = '{0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0};
        run(1, "queue", 16'd1);

        // Toggle H4, triggers at 0 and 1.
        t_tab = '{1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        d_tab = '{0,1,1,1,1,0,0,0, 0,0,0,0,0,0,0,0};
        b_tab = '{0,1,1,1,1,1,1,1, 1,0,0,0,0,0,0,0};
        p_tab = '{0,0,1,1,1,0,0,0, 0,0,0,0,0,0,0,0};
        r_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        run(2, "toggle", 16'd0);

        // Pulse H1 L1, trig held 8 cycles: consume+requeue on GUARD end.
        t_tab = '{1,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0};
        d_tab = '{0,1,0,1,0,1,0,1, 0,1,0,0,0,0,0,0};
        b_tab = '{0,1,1,1,1,1,1,1, 1,1,1,0,0,0,0,0};
        p_tab = '{0,0,1,1,1,1,1,1, 1,0,0,0,0,0,0,0};
        r_tab = '{0,0,0,0,1,0,1,0, 1,0,0,0,0,0,0,0};
        run(3, "stream", 16'd3);

        // Illegal mode: everything stays idle.
        t_tab = '{1,1,0,1,0,0,1,1, 1,0,1,0,0,0,0,0};
        d_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        b_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        p_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        r_tab = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        run(4, "illegal", 16'd0);

        // Reset mid-ACTIVE with a queued trigger (instance 1, drop_cnt is 1).
        trig_v[1] = 1'b1;
        tick();
        check("midrst start dout", {15'd0, dout_v[1]}, 16'd1);
        trig_v[1] = 1'b1;
        tick();
        check("midrst pend set", {15'd0, pend_v[1]}, 16'd1);
        check("midrst busy set", {15'd0, busy_v[1]}, 16'd1);
        trig_v[1] = 1'b0;
        rstn_v[1] = 1'b0;
        tick();
        check("midrst dout",     {15'd0, dout_v[1]}, 16'd0);
        check("midrst pend",     {15'd0, pend_v[1]}, 16'd0);
        check("midrst busy",     {15'd0, busy_v[1]}, 16'd0);
        check("midrst drop_cnt", cnt_v[1], 16'd0);
        rstn_v[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("postrst dout[%0d]", i), {15'd0, dout_v[1]}, 16'd0);
            check($sformatf("postrst busy[%0d]", i), {15'd0, busy_v[1]}, 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
